// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: program-memory request/acknowledge port plus the
// instruction valid/ready port towards the opcode decoder.
//
// Handshake rules:
//   memory side  - mem_req/mem_addr are held stable from the first request
//                  cycle until an edge where mem_ack=1. That edge transfers
//                  mem_rdata. mem_ack may be high in the very first request
//                  cycle (zero wait). mem_ack while mem_req=0 is ignored.
//   decoder side - instr/instr_valid are held stable until an edge where
//                  instr_valid=1 and instr_ready=1. That edge consumes instr.
//                  instr_ready may be high before instr_valid rises.
interface fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic [7:0]        instr;
    logic              instr_valid;
    logic              instr_ready;

    // Fetch unit side
    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output instr,
        output instr_valid,
        input  instr_ready
    );

    // Program memory and decoder side
    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one byte per request from
// program memory, holds it in the instruction register until the decoder
// takes it, and then either fetches the next byte, jumps, or halts.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_unit_if.master      bus,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    output logic              halted,
    output logic [15:0]       fetch_count,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        instr_q;
    logic [15:0]       count_q;
    logic              capture;
    logic              accept;

    // Memory beat lands only while a request is outstanding; decoder takes
    // the instruction only while one is being presented.
    assign capture = (state == REQ)  && bus.mem_ack;
    assign accept  = (state == HOLD) && bus.instr_ready;

    // State register; reset returns to IDLE, dropping any pending request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt       = state;
        bus.mem_req     = 1'b0;
        bus.instr_valid = 1'b0;
        halted          = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = REQ;
            end
            REQ: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                bus.instr_valid = 1'b1;
                if (bus.instr_ready) begin
                    state_nxt = halt ? HALTED : REQ;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // PC, instruction register and capture counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            instr_q <= 8'h00;
            count_q <= 16'h0000;
        end else begin
            if (capture) begin
                instr_q <= bus.mem_rdata;
                pc      <= pc + 1'b1;
                if (count_q != 16'hFFFF) begin
                    count_q <= count_q + 16'd1;
                end
            end
            // capture and accept never coincide, so a jump simply replaces
            // the increment made when this instruction was captured
            if (accept && jump_en) begin
                pc <= jump_addr;
            end
        end
    end

    assign bus.mem_addr = pc;
    assign bus.instr    = instr_q;
    assign fetch_count  = count_q;
    assign state_dbg    = state;

endmodule
